// File: rtl/stopwatch_counter.sv
// Minutes:seconds stopwatch with up/down counting, saturating down-count,
// manual adjust mode, pause toggle and combinational BCD digit outputs.
module stopwatch_counter #(
    parameter int unsigned MIN_MAX = 99,
    parameter int unsigned SEC_MAX = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_tick,
    input  logic       adj_tick,
    input  logic       adj,
    input  logic       sel,
    input  logic       dir,
    input  logic       pause_tog,
    output logic [6:0] minutes,
    output logic [5:0] seconds,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       paused,
    output logic       zero,
    output logic       wrap
);

    localparam logic [6:0] MIN_TOP = MIN_MAX[6:0];
    localparam logic [5:0] SEC_TOP = SEC_MAX[5:0];

    logic [6:0] min_nxt;
    logic [5:0] sec_nxt;
    logic       wrap_nxt;
    logic       count_en;
    logic       adj_en;

    // paused is the pre-toggle value here, so a same-cycle pause_tog never
    // affects this cycle's count decision.
    assign count_en = sec_tick & ~adj & ~paused;
    assign adj_en   = adj & adj_tick;

    always_comb begin
        min_nxt  = minutes;
        sec_nxt  = seconds;
        wrap_nxt = 1'b0;
        if (adj_en) begin
            if (sel) begin
                sec_nxt = (seconds == SEC_TOP) ? 6'd0 : seconds + 6'd1;
            end else begin
                min_nxt = (minutes == MIN_TOP) ? 7'd0 : minutes + 7'd1;
            end
        end else if (count_en) begin
            if (!dir) begin
                if (seconds == SEC_TOP) begin
                    sec_nxt = 6'd0;
                    if (minutes == MIN_TOP) begin
                        min_nxt  = 7'd0;
                        wrap_nxt = 1'b1;
                    end else begin
                        min_nxt = minutes + 7'd1;
                    end
                end else begin
                    sec_nxt = seconds + 6'd1;
                end
            end else begin
                // Down count saturates at 00:00.
                if (seconds != 6'd0) begin
                    sec_nxt = seconds - 6'd1;
                end else if (minutes != 7'd0) begin
                    sec_nxt = SEC_TOP;
                    min_nxt = minutes - 7'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            minutes <= 7'd0;
            seconds <= 6'd0;
            paused  <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            minutes <= min_nxt;
            seconds <= sec_nxt;
            paused  <= paused ^ pause_tog;
            wrap    <= wrap_nxt;
        end
    end

    function automatic logic [3:0] bcd_tens(input logic [6:0] v);
        logic [6:0] q;
        q = v / 7'd10;
        return q[3:0];
    endfunction

    function automatic logic [3:0] bcd_ones(input logic [6:0] v);
        logic [6:0] r;
        r = v % 7'd10;
        return r[3:0];
    endfunction

    assign min_tens = bcd_tens(minutes);
    assign min_ones = bcd_ones(minutes);
    assign sec_tens = bcd_tens({1'b0, seconds});
    assign sec_ones = bcd_ones({1'b0, seconds});
    assign zero     = (minutes == 7'd0) && (seconds == 6'd0);

endmodule
